// File: rtl/fetch_stage2.sv
// fetch_stage2: second fetch stage. Latches the fetch-1 bundle, predecodes its
// four slots, truncates the bundle at the first taken control transfer, and
// redirects fetch-1 when the BTB missed or mispredicted a direct target.
//
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   stall_i                         hold the latch
//   flush_i, recoverFlag_i,
//   exceptionFlag_i                 invalidate the latched bundle
//   fs1Ready_i                      incoming bundle valid
//   instructionBundle_i, pc_i       incoming bundle (slot 0 in low bits) and slot-0 PC
//   btbHit[0-3]_i, targetAddr[0-3]_i,
//   prediction[0-3]_i               per-slot BTB/predictor information
//   flagRecoverID_o, targetAddrID_o redirect fetch-1 (target 0 for a return)
//   flagCallID_o, callPCID_o        BTB-missed call and its return address
//   flagRtrID_o                     BTB-missed return, fetch-1 uses RAS checkpoint
//   fs2Ready_o, instBundle_o, pc_o  latched bundle
//   validMask_o                     per-slot valid after truncation
//   predTarget_o                    next fetch PC implied by this bundle
//
// Build option: define FS2_FALSE_HIT_REPAIR_EN to redirect a non-control slot that
// the BTB reported as a predicted-taken hit back onto the sequential path.
// Instruction encoding: each 64-bit slot carries a MIPS-format word in its low 32 bits.
module fetch_stage2 #(
    parameter int SIZE_PC            = 32,
    parameter int INSTRUCTION_BUNDLE = 256
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          stall_i,
    input  logic                          flush_i,
    input  logic                          recoverFlag_i,
    input  logic                          exceptionFlag_i,
    input  logic                          fs1Ready_i,
    input  logic [INSTRUCTION_BUNDLE-1:0] instructionBundle_i,
    input  logic [SIZE_PC-1:0]            pc_i,
    input  logic                          btbHit0_i,
    input  logic                          btbHit1_i,
    input  logic                          btbHit2_i,
    input  logic                          btbHit3_i,
    input  logic [SIZE_PC-1:0]            targetAddr0_i,
    input  logic [SIZE_PC-1:0]            targetAddr1_i,
    input  logic [SIZE_PC-1:0]            targetAddr2_i,
    input  logic [SIZE_PC-1:0]            targetAddr3_i,
    input  logic                          prediction0_i,
    input  logic                          prediction1_i,
    input  logic                          prediction2_i,
    input  logic                          prediction3_i,
    output logic                          flagRecoverID_o,
    output logic [SIZE_PC-1:0]            targetAddrID_o,
    output logic                          flagCallID_o,
    output logic [SIZE_PC-1:0]            callPCID_o,
    output logic                          flagRtrID_o,
    output logic                          fs2Ready_o,
    output logic [INSTRUCTION_BUNDLE-1:0] instBundle_o,
    output logic [SIZE_PC-1:0]            pc_o,
    output logic [3:0]                    validMask_o,
    output logic [SIZE_PC-1:0]            predTarget_o
);
    localparam logic [5:0] OP_SPECIAL = 6'h00, OP_REGIMM = 6'h01, OP_J = 6'h02, OP_JAL = 6'h03;
    localparam logic [5:0] OP_BEQ = 6'h04, OP_BNE = 6'h05, OP_BLEZ = 6'h06, OP_BGTZ = 6'h07;
    localparam logic [5:0] FN_JR = 6'h08, FN_JALR = 6'h09;
    localparam logic [4:0] RT_BLTZ = 5'd0, RT_BGEZ = 5'd1, REG_RA = 5'd31;

    logic                          valid_q, valid_d;
    logic [INSTRUCTION_BUNDLE-1:0] bundle_q, bundle_d;
    logic [SIZE_PC-1:0]            pc_q, pc_d;
    logic [3:0]                    hit_q, hit_d, pred_q, pred_d;
    logic [3:0][SIZE_PC-1:0]       tgt_q, tgt_d;

    logic [3:0][31:0]        w;
    logic [3:0][SIZE_PC-1:0] slot_pc, slot_tgt;
    logic [3:0]              is_jmp, is_call, is_cond, is_ret, taken, need;
    logic [1:0]              t;
    logic                    found, redirect;
    logic [3:0]              mask;
`ifdef FS2_FALSE_HIT_REPAIR_EN
    logic [3:0]              is_ctrl;
`endif

    always_comb begin
        for (int k = 0; k < 4; k++) begin
            w[k]       = bundle_q[64*k +: 32];
            slot_pc[k] = pc_q + SIZE_PC'(8 * k);
            is_jmp[k]  = w[k][31:26] == OP_J;
            is_call[k] = w[k][31:26] == OP_JAL;
            is_cond[k] = (w[k][31:26] inside {OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ}) ||
                         (w[k][31:26] == OP_REGIMM && (w[k][20:16] == RT_BLTZ || w[k][20:16] == RT_BGEZ));
            is_ret[k]  = w[k][31:26] == OP_SPECIAL && w[k][5:0] == FN_JR && w[k][25:21] == REG_RA;
            // A return's target comes from the RAS, so only a BTB-hit target is meaningful here.
            slot_tgt[k] = (is_jmp[k] | is_call[k]) ? {slot_pc[k][31:28], w[k][25:0], 2'b00} :
                          is_cond[k] ? slot_pc[k] + 32'd8 + {{14{w[k][15]}}, w[k][15:0], 2'b00} :
                          is_ret[k]  ? (hit_q[k] ? tgt_q[k] : '0) :
                          slot_pc[k] + 32'd8;
`ifdef FS2_FALSE_HIT_REPAIR_EN
            is_ctrl[k] = is_jmp[k] | is_call[k] | is_cond[k] |
                         (w[k][31:26] == OP_SPECIAL && (w[k][5:0] == FN_JR || w[k][5:0] == FN_JALR));
            taken[k]   = is_jmp[k] | is_call[k] | is_ret[k] | (is_cond[k] & hit_q[k] & pred_q[k]) |
                         (~is_ctrl[k] & hit_q[k] & pred_q[k]);
            need[k]    = ~is_ctrl[k] | (is_ret[k] ? ~hit_q[k] : (~hit_q[k] | (tgt_q[k] != slot_tgt[k])));
`else
            taken[k]   = is_jmp[k] | is_call[k] | is_ret[k] | (is_cond[k] & hit_q[k] & pred_q[k]);
            need[k]    = is_ret[k] ? ~hit_q[k] : (~hit_q[k] | (tgt_q[k] != slot_tgt[k]));
`endif
        end
        found = 1'b0;
        t     = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            if (taken[k]) begin
                found = 1'b1;
                t     = 2'(k);
            end
        end
        mask     = found ? 4'((5'd2 << t) - 5'd1) : 4'hf;
        redirect = valid_q & found & need[t];
    end

    assign flagRecoverID_o = redirect;
    assign targetAddrID_o  = (redirect && !is_ret[t]) ? slot_tgt[t] : '0;
    assign flagCallID_o    = redirect & is_call[t] & ~hit_q[t];
    assign callPCID_o      = flagCallID_o ? slot_pc[t] + 32'd8 : '0;
    assign flagRtrID_o     = redirect & is_ret[t];
    assign fs2Ready_o      = valid_q;
    assign instBundle_o    = bundle_q;
    assign pc_o            = pc_q;
    assign validMask_o     = valid_q ? mask : '0;
    assign predTarget_o    = !valid_q ? '0 : found ? slot_tgt[t] : pc_q + 32'd32;

    always_comb begin
        valid_d  = valid_q;
        bundle_d = bundle_q;
        pc_d     = pc_q;
        hit_d    = hit_q;
        pred_d   = pred_q;
        tgt_d    = tgt_q;
        if (reset) begin
            valid_d  = 1'b0;
            bundle_d = '0;
            pc_d     = '0;
            hit_d    = '0;
            pred_d   = '0;
            tgt_d    = '0;
        end else if (flush_i | recoverFlag_i | exceptionFlag_i) begin
            valid_d = 1'b0;
        end else if (!stall_i && redirect) begin
            // Fetch-1 is delivering a wrong-path bundle this cycle; drop it.
            valid_d = 1'b0;
        end else if (!stall_i) begin
            valid_d  = fs1Ready_i;
            bundle_d = instructionBundle_i;
            pc_d     = pc_i;
            hit_d    = {btbHit3_i, btbHit2_i, btbHit1_i, btbHit0_i};
            pred_d   = {prediction3_i, prediction2_i, prediction1_i, prediction0_i};
            tgt_d    = {targetAddr3_i, targetAddr2_i, targetAddr1_i, targetAddr0_i};
        end
    end

    always_ff @(posedge clk) begin
        valid_q  <= valid_d;
        bundle_q <= bundle_d;
        pc_q     <= pc_d;
        hit_q    <= hit_d;
        pred_q   <= pred_d;
        tgt_q    <= tgt_d;
    end
endmodule

// File: tb/tb_fetch_stage2.sv
// tb_fetch_stage2: scoreboard bench for fetch_stage2 with a slot-rule reference model.
module tb_fetch_stage2;
    logic             clk = 1'b0;
    logic             reset, stall_i, flush_i, recoverFlag_i, exceptionFlag_i, fs1Ready_i;
    logic [255:0]     bundle_in;
    logic [31:0]      pc_in;
    logic [3:0]       hit_in, pred_in;
    logic [3:0][31:0] tgt_in;
    logic             flagRecoverID_o, flagCallID_o, flagRtrID_o, fs2Ready_o;
    logic [31:0]      targetAddrID_o, callPCID_o, pc_o, predTarget_o;
    logic [255:0]     instBundle_o;
    logic [3:0]       validMask_o;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fetch_stage2 dut (
        .clk(clk), .reset(reset), .stall_i(stall_i), .flush_i(flush_i),
        .recoverFlag_i(recoverFlag_i), .exceptionFlag_i(exceptionFlag_i), .fs1Ready_i(fs1Ready_i),
        .instructionBundle_i(bundle_in), .pc_i(pc_in),
        .btbHit0_i(hit_in[0]), .btbHit1_i(hit_in[1]), .btbHit2_i(hit_in[2]), .btbHit3_i(hit_in[3]),
        .targetAddr0_i(tgt_in[0]), .targetAddr1_i(tgt_in[1]), .targetAddr2_i(tgt_in[2]), .targetAddr3_i(tgt_in[3]),
        .prediction0_i(pred_in[0]), .prediction1_i(pred_in[1]), .prediction2_i(pred_in[2]), .prediction3_i(pred_in[3]),
        .flagRecoverID_o(flagRecoverID_o), .targetAddrID_o(targetAddrID_o),
        .flagCallID_o(flagCallID_o), .callPCID_o(callPCID_o), .flagRtrID_o(flagRtrID_o),
        .fs2Ready_o(fs2Ready_o), .instBundle_o(instBundle_o), .pc_o(pc_o),
        .validMask_o(validMask_o), .predTarget_o(predTarget_o)
    );

    typedef enum {K_NONE, K_COND, K_JMP, K_CALL, K_RET, K_IND} kind_e;

    typedef struct packed {
        logic             v;
        logic [255:0]     b;
        logic [31:0]      pc;
        logic [3:0]       hit;
        logic [3:0]       pred;
        logic [3:0][31:0] tgt;
    } st_t;

    typedef struct packed {
        logic         v;
        logic         rec;
        logic [31:0]  tgt;
        logic         call;
        logic [31:0]  cpc;
        logic         rtr;
        logic [3:0]   mask;
        logic [31:0]  ptgt;
        logic [31:0]  pc;
        logic [255:0] b;
    } exp_t;

    st_t  m = '0;
    exp_t q[$];

    localparam logic [31:0] NOP = 32'h2000_0000;

    function automatic kind_e kind_of(logic [31:0] w);
        case (w[31:26])
            6'h02: return K_JMP;
            6'h03: return K_CALL;
            6'h04, 6'h05, 6'h06, 6'h07: return K_COND;
            6'h01: if (w[20:16] <= 5'd1) return K_COND; else return K_NONE;
            6'h00: begin
                if (w[5:0] == 6'h08 && w[25:21] == 5'd31) return K_RET;
                if (w[5:0] == 6'h08 || w[5:0] == 6'h09) return K_IND;
                return K_NONE;
            end
            default: return K_NONE;
        endcase
    endfunction

    function automatic logic [31:0] slot_target(logic [31:0] w, logic [31:0] spc);
        int off;
        kind_e kd = kind_of(w);
        if (kd == K_JMP || kd == K_CALL) return {spc[31:28], w[25:0], 2'b00};
        off = 4 * int'($signed(w[15:0]));
        if (kd == K_COND) return spc + 32'd8 + 32'(off);
        return spc + 32'd8;
    endfunction

    function automatic exp_t model_out(st_t s);
        exp_t e = '0;
        e.v = s.v;
        e.pc = s.pc;
        e.b = s.b;
        if (!s.v) return e;
        e.mask = 4'hf;
        e.ptgt = s.pc + 32'd32;
        for (int k = 0; k < 4; k++) begin
            logic [31:0] w;
            logic [31:0] spc;
            logic [31:0] target;
            kind_e kd;
            w = s.b[64*k +: 32];
            spc = s.pc + 32'(8 * k);
            kd = kind_of(w);
            target = (kd == K_RET) ? (s.hit[k] ? s.tgt[k] : 32'd0) : slot_target(w, spc);
            if (kd == K_JMP || kd == K_CALL || kd == K_RET || (kd == K_COND && s.hit[k] && s.pred[k])) begin
                e.mask = 4'((1 << (k + 1)) - 1);
                e.ptgt = target;
                if (kd == K_RET) begin
                    e.rec = !s.hit[k];
                    e.rtr = !s.hit[k];
                end else if (!s.hit[k] || s.tgt[k] != target) begin
                    e.rec = 1'b1;
                    e.tgt = target;
                    if (kd == K_CALL && !s.hit[k]) begin
                        e.call = 1'b1;
                        e.cpc = spc + 32'd8;
                    end
                end
                return e;
            end
        end
        return e;
    endfunction

    function automatic logic [63:0] gen_inst();
        logic [31:0] w = $urandom;
        case ($urandom_range(0, 9))
            0, 1: w[31:26] = 6'h08 + 6'($urandom_range(0, 7));
            2: begin w[31:26] = 6'h00; w[5:0] = 6'h20; end
            3: w[31:26] = 6'h02;
            4: w[31:26] = 6'h03;
            5: w[31:26] = 6'h04 + 6'($urandom_range(0, 3));
            6: begin w[31:26] = 6'h01; w[20:16] = 5'($urandom_range(0, 1)); end
            7: begin w[31:26] = 6'h00; w[25:21] = 5'd31; w[5:0] = 6'h08; end
            8: begin w[31:26] = 6'h00; w[25:21] = 5'($urandom_range(0, 30)); w[5:0] = 6'h08; end
            default: begin w[31:26] = 6'h00; w[5:0] = 6'h09; end
        endcase
        return {32'($urandom), w};
    endfunction

    function automatic logic [255:0] mk(logic [31:0] w0, logic [31:0] w1, logic [31:0] w2, logic [31:0] w3);
        return {32'h0, w3, 32'h0, w2, 32'h0, w1, 32'h0, w0};
    endfunction

    task automatic cmp(string name, logic [255:0] act, logic [255:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic tick();
        if (reset) m = '0;
        else if (flush_i | recoverFlag_i | exceptionFlag_i) m.v = 1'b0;
        else if (!stall_i && model_out(m).rec) m.v = 1'b0;
        else if (!stall_i) m = '{v: fs1Ready_i, b: bundle_in, pc: pc_in, hit: hit_in, pred: pred_in, tgt: tgt_in};
        q.push_back(model_out(m));
        @(posedge clk);
        #1;
    endtask

    task automatic load(logic [255:0] b, logic [31:0] pc, logic [3:0] hit, logic [3:0] pred, logic [3:0][31:0] tgt);
        bundle_in = b; pc_in = pc; hit_in = hit; pred_in = pred; tgt_in = tgt;
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0; stall_i = 1'b0; fs1Ready_i = 1'b1;
        tick();
    endtask

    initial forever begin
        exp_t e;
        @(posedge clk);
        #2;
        if (q.size() > 0) begin
            e = q.pop_front();
            cmp("fs2Ready", fs2Ready_o, e.v);
            cmp("flagRecover", flagRecoverID_o, e.rec);
            cmp("targetAddrID", targetAddrID_o, e.tgt);
            cmp("flagCall", flagCallID_o, e.call);
            cmp("callPC", callPCID_o, e.cpc);
            cmp("flagRtr", flagRtrID_o, e.rtr);
            cmp("validMask", validMask_o, e.mask);
            cmp("predTarget", predTarget_o, e.ptgt);
            cmp("pc_o", pc_o, e.pc);
            cmp("instBundle", instBundle_o, e.b);
        end
    end

    initial begin
        reset = 1'b1; stall_i = 1'b0; flush_i = 1'b0; recoverFlag_i = 1'b0; exceptionFlag_i = 1'b0;
        fs1Ready_i = 1'b1; bundle_in = '1; pc_in = 32'h1234_5678; hit_in = '1; pred_in = '1; tgt_in = '1;
        tick();
        tick();
        cmp("rst_ready", fs2Ready_o, 0);
        cmp("rst_mask", validMask_o, 0);
        cmp("rst_pc", pc_o, 0);
        cmp("rst_recover", flagRecoverID_o, 0);
        reset = 1'b0;

        load(mk(NOP, 32'h0800_0400, NOP, NOP), 32'h1000, 4'b0000, 4'b0000, '0);
        cmp("j_recover", flagRecoverID_o, 1);
        cmp("j_target", targetAddrID_o, 32'h1000);
        cmp("j_mask", validMask_o, 4'b0011);
        tick();
        cmp("j_squash", fs2Ready_o, 0);

        load(mk(32'h0C00_0900, NOP, NOP, NOP), 32'h2000, 4'b0000, 4'b0000, '0);
        cmp("jal_call", flagCallID_o, 1);
        cmp("jal_callpc", callPCID_o, 32'h2008);
        cmp("jal_mask", validMask_o, 4'b0001);
        cmp("jal_target", targetAddrID_o, 32'h2400);

        load(mk(NOP, NOP, 32'h1000_FFFF, NOP), 32'h2000, 4'b0100, 4'b0100, {32'h0, 32'h2014, 32'h0, 32'h0});
        cmp("beq_recover", flagRecoverID_o, 0);
        cmp("beq_predtgt", predTarget_o, 32'h2014);
        cmp("beq_mask", validMask_o, 4'b0111);

        load(mk(NOP, NOP, NOP, 32'h03E0_0008), 32'h3000, 4'b0000, 4'b0000, '0);
        cmp("ret_rtr", flagRtrID_o, 1);
        cmp("ret_target", targetAddrID_o, 0);
        stall_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            cmp("ret_stall_rtr", flagRtrID_o, 1);
        end
        stall_i = 1'b0;
        tick();
        cmp("ret_squash", fs2Ready_o, 0);

        load(mk(NOP, 32'h0800_0400, NOP, NOP), 32'h1000, 4'b0000, 4'b0000, '0);
        flush_i = 1'b1; reset = 1'b1;
        tick();
        cmp("rstflush_ready", fs2Ready_o, 0);
        cmp("rstflush_recover", flagRecoverID_o, 0);
        cmp("rstflush_mask", validMask_o, 0);
        cmp("rstflush_pc", pc_o, 0);
        flush_i = 1'b0; reset = 1'b0;

        for (int n = 0; n < 3000; n++) begin
            reset = $urandom_range(0, 99) == 0;
            flush_i = $urandom_range(0, 19) == 0;
            recoverFlag_i = $urandom_range(0, 39) == 0;
            exceptionFlag_i = $urandom_range(0, 39) == 0;
            stall_i = $urandom_range(0, 3) == 0;
            fs1Ready_i = $urandom_range(0, 4) != 0;
            pc_in = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFE0 : 32'($urandom);
            pc_in[2:0] = 3'b000;
            for (int k = 0; k < 4; k++) bundle_in[64*k +: 64] = gen_inst();
            hit_in = 4'($urandom);
            pred_in = 4'($urandom);
            for (int k = 0; k < 4; k++)
                tgt_in[k] = $urandom_range(0, 1) ? slot_target(bundle_in[64*k +: 32], pc_in + 32'(8 * k)) : 32'($urandom);
            tick();
        end

        reset = 1'b0; flush_i = 1'b0; recoverFlag_i = 1'b0; exceptionFlag_i = 1'b0; stall_i = 1'b0;
        tick();
        for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
        #2;
        cmp("scoreboard_drained", 32'(q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
